scan_index_gen: RTL



---
 rtl/scan_index_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/scan_index_gen.sv
// ---------------------------------------------------------------------------
// scan_index_gen
//
// Sequential 3-bit index generator feeding a downstream one-hot 3-to-8
// decoder (a = MSB, c = LSB). A prescaler divides the clock so that the
// index steps once every PRESCALE enabled cycles. On each step the index
// moves up, down, ping-pongs between 0 and 7, or holds, according to mode.
// A load strobe writes the index directly and restarts the prescaler phase.
//
// Parameters
//   PRESCALE  clock cycles per step (>= 1; 1 steps on every enabled edge)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   en        prescaler enable; low freezes prescaler and index
//   mode      00 up, 01 down, 10 ping-pong, 11 hold
//   load      single-cycle load strobe (beats a coincident step)
//   load_val  index value written on load
//   a, b, c   index bits 2, 1, 0 (registered)
//   tick      one-cycle pulse on every step (registered)
//   wrap      one-cycle pulse on wrap-around or ping-pong reversal
// ---------------------------------------------------------------------------
module scan_index_gen #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       tick,
    output logic       wrap
);

    // Derived prescaler width; at least one bit so PRESCALE=1 still builds.
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    dir_t             r_dir;
    logic             r_tick;
    logic             r_wrap;

    logic             w_step;

    // A step happens on the last enabled cycle of the prescaler period.
    assign w_step = en && (r_cnt == CNT_LAST);

    // Single sequential block: prescaler, index and ping-pong direction FSM.
    // Priority is rst, then load, then step, then idle/count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 3'd0;
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (load) begin
            // Load also restarts the prescaler phase and re-arms ping-pong upward.
            r_idx  <= load_val;
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_wrap <= 1'b0;
            case (mode)
                MODE_UP: begin
                    r_idx  <= r_idx + 3'd1;
                    r_wrap <= (r_idx == 3'd7);
                end
                MODE_DOWN: begin
                    r_idx  <= r_idx - 3'd1;
                    r_wrap <= (r_idx == 3'd0);
                end
                MODE_PP: begin
                    // Reversal steps to the neighbour rather than repeating the end value.
                    case (r_dir)
                        DIR_UP: begin
                            if (r_idx == 3'd7) begin
                                r_idx  <= 3'd6;
                                r_dir  <= DIR_DOWN;
                                r_wrap <= 1'b1;
                            end else begin
                                r_idx  <= r_idx + 3'd1;
                            end
                        end
                        default: begin
                            if (r_idx == 3'd0) begin
                                r_idx  <= 3'd1;
                                r_dir  <= DIR_UP;
                                r_wrap <= 1'b1;
                            end else begin
                                r_idx  <= r_idx - 3'd1;
                            end
                        end
                    endcase
                end
                default: begin
                    // Hold: tick still pulses, index and direction stay put.
                    r_idx <= r_idx;
                end
            endcase
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign a    = r_idx[2];
    assign b    = r_idx[1];
    assign c    = r_idx[0];
    assign tick = r_tick;
    assign wrap = r_wrap;

endmodule
